// File: rtl/cnn_weight_bank.sv
// cnn_weight_bank: run-time loadable store of signed CNN filter weights.
// Weights stream in over a valid/ready port in (filter, channel, row, col)
// order. A whole KxK x C kernel is returned one cycle after a read request.
// Optional feature macro: WBANK_PINGPONG_EN (active/shadow banks, swap on commit).
module cnn_weight_bank #(
  parameter int WIDTH = 17,
  parameter int K     = 3,
  parameter int C     = 3,
  parameter int NF    = 4,
  localparam int FW   = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    load_done,
  output logic                    load_err,
  output logic                    bank_ready,
  input  logic                    rd_en,
  input  logic [FW-1:0]           rd_filter,
  output logic                    rd_valid,
  output logic [WIDTH*C*K*K-1:0]  rd_kernel,
  output logic                    rd_err
);

  localparam int KS    = C * K * K;
  localparam int DEPTH = NF * KS;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = (KS > 1) ? $clog2(KS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, LOADED} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [FW-1:0]     wr_f;
  logic [EW-1:0]     wr_e;
  logic              hs, last_word, done_nx, err_nx, accept;
  logic [WIDTH*KS-1:0] kernel_p0;

  assign s_ready   = (state == LOAD);
  // load_start takes priority over a word presented in the same cycle
  assign hs        = s_ready & s_valid & ~load_start;
  assign last_word = (cnt == CW'(DEPTH - 1));
  assign accept    = rd_en & bank_ready & ({1'b0, rd_filter} < (FW + 1)'(NF));

  // Next-state and load completion/error decode
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (load_start) begin
      state_nx = LOAD;
    end else if (hs) begin
      if (last_word && s_last) begin
        state_nx = LOADED;
        done_nx  = 1'b1;
      end else if (last_word || s_last) begin
        state_nx = IDLE;
        err_nx   = 1'b1;
      end
    end
  end

  // State register, word counter and load status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_f      <= '0;
      wr_e      <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      load_done <= done_nx;
      load_err  <= err_nx;
      if (load_start) begin
        cnt  <= '0;
        wr_f <= '0;
        wr_e <= '0;
      end else if (hs) begin
        cnt <= cnt + 1'b1;
        // filter/tap split of the counter avoids a divider on the write address
        if (wr_e == EW'(KS - 1)) begin
          wr_e <= '0;
          wr_f <= wr_f + 1'b1;
        end else begin
          wr_e <= wr_e + 1'b1;
        end
      end
    end
  end

`ifdef WBANK_PINGPONG_EN
  logic signed [WIDTH-1:0] mem [2][NF][KS];
  logic act, had_set, rd_bank;

  // A read in the very first commit cycle has no older set, so it sees the new one
  assign rd_bank = (load_done & ~had_set) ? ~act : act;

  // Bank availability and active-bank swap at the end of the commit cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_ready <= 1'b0;
      act        <= 1'b0;
      had_set    <= 1'b0;
    end else begin
      if (done_nx) bank_ready <= 1'b1;
      if (load_done) begin
        act     <= ~act;
        had_set <= 1'b1;
      end
    end
  end

  // Loads only ever touch the shadow bank
  always_ff @(posedge clk) begin
    if (hs) mem[~act][wr_f][wr_e] <= s_data;
  end

  for (genvar i = 0; i < KS; i++) begin : g_tap
    assign kernel_p0[i*WIDTH +: WIDTH] = mem[rd_bank][rd_filter][i];
  end
`else
  logic signed [WIDTH-1:0] mem [NF][KS];

  // Single bank: contents are invalid from load_start until a good commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_ready <= 1'b0;
    end else if (load_start) begin
      bank_ready <= 1'b0;
    end else if (done_nx) begin
      bank_ready <= 1'b1;
    end
  end

  // Weight storage write port, deliberately not reset
  always_ff @(posedge clk) begin
    if (hs) mem[wr_f][wr_e] <= s_data;
  end

  for (genvar i = 0; i < KS; i++) begin : g_tap
    assign kernel_p0[i*WIDTH +: WIDTH] = mem[rd_filter][i];
  end
`endif

  // p0 -> p1: registered kernel output with fixed one-cycle latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      rd_kernel <= '0;
    end else begin
      rd_valid <= accept;
      rd_err   <= rd_en & ~accept;
      if (accept) rd_kernel <= kernel_p0;
    end
  end

endmodule

// File: tb/tb_cnn_weight_bank.sv
// Self-checking bench for cnn_weight_bank with a word-level behavioural model.
module tb_cnn_weight_bank;

  localparam int WIDTH = 17;
  localparam int K     = 3;
  localparam int C     = 3;
  localparam int NF    = 4;
  localparam int KS    = C * K * K;
  localparam int DEPTH = NF * KS;
  localparam int FW    = $clog2(NF);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n = 1'b0;
  logic                   load_start = 1'b0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data = '0;
  logic                   s_last = 1'b0;
  logic                   load_done, load_err, bank_ready;
  logic                   rd_en = 1'b0;
  logic [FW-1:0]          rd_filter = '0;
  logic                   rd_valid, rd_err;
  logic [WIDTH*KS-1:0]    rd_kernel;

  cnn_weight_bank #(.WIDTH(WIDTH), .K(K), .C(C), .NF(NF)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .load_done(load_done),
    .load_err(load_err), .bank_ready(bank_ready), .rd_en(rd_en),
    .rd_filter(rd_filter), .rd_valid(rd_valid), .rd_kernel(rd_kernel),
    .rd_err(rd_err)
  );

  // Behavioural model: committed set, set being loaded, and expected outputs
  logic [WIDTH-1:0]    m_act [DEPTH];
  logic [WIDTH-1:0]    m_shd [DEPTH];
  bit                  m_load = 0, m_ready = 0, m_had = 0;
  int                  m_cnt = 0;
  logic                e_valid = 0, e_err = 0, e_done = 0, e_lerr = 0;
  logic [WIDTH*KS-1:0] e_kernel = '0;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;
  bit rd_rand = 0;

  function automatic logic [WIDTH*KS-1:0] pack(input bit from_shd, input int f);
    logic [WIDTH*KS-1:0] k;
    k = '0;
    for (int i = 0; i < KS; i++)
      k[i*WIDTH +: WIDTH] = from_shd ? m_shd[f*KS+i] : m_act[f*KS+i];
    return k;
  endfunction

  task automatic chk(input string name, input logic [WIDTH*KS-1:0] act,
                     input logic [WIDTH*KS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] elem(input int j);
    return rd_kernel[j*WIDTH +: WIDTH];
  endfunction

  task automatic compare_all();
    chk("s_ready",    {458'd0, s_ready},    {458'd0, m_load});
    chk("bank_ready", {458'd0, bank_ready}, {458'd0, m_ready});
    chk("load_done",  {458'd0, load_done},  {458'd0, e_done});
    chk("load_err",   {458'd0, load_err},   {458'd0, e_lerr});
    chk("rd_valid",   {458'd0, rd_valid},   {458'd0, e_valid});
    chk("rd_err",     {458'd0, rd_err},     {458'd0, e_err});
    chk("rd_kernel",  rd_kernel,            e_kernel);
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    bit prev_done, acc, last, use_shd;
    if (!rst_n) begin
      m_load = 0; m_ready = 0; m_had = 0; m_cnt = 0;
      e_valid = 0; e_err = 0; e_done = 0; e_lerr = 0; e_kernel = '0;
      return;
    end
    prev_done = e_done;
    acc = rd_en && m_ready && (int'(rd_filter) < NF);
    e_valid = acc;
    e_err   = rd_en && !acc;
`ifdef WBANK_PINGPONG_EN
    use_shd = prev_done && !m_had;
`else
    use_shd = 0;
`endif
    if (acc) e_kernel = pack(use_shd, int'(rd_filter));
`ifdef WBANK_PINGPONG_EN
    if (prev_done) begin
      for (int i = 0; i < DEPTH; i++) m_act[i] = m_shd[i];
      m_had = 1;
    end
`endif
    e_done = 0;
    e_lerr = 0;
    if (load_start) begin
      m_load = 1;
      m_cnt  = 0;
`ifndef WBANK_PINGPONG_EN
      m_ready = 0;
`endif
    end else if (m_load && s_valid) begin
`ifdef WBANK_PINGPONG_EN
      m_shd[m_cnt] = s_data;
`else
      m_act[m_cnt] = s_data;
`endif
      last = (m_cnt == DEPTH - 1);
      m_cnt++;
      if (last || s_last) begin
        m_load = 0;
        if (last && s_last) begin
          e_done  = 1;
          m_ready = 1;
        end else begin
          e_lerr = 1;
        end
      end
    end
  endtask

  // One clock: compare at negedge, model at posedge, drive just after posedge
  task automatic cyc();
    @(negedge clk);
    if (chk_on) compare_all();
    @(posedge clk);
    model_step();
    #1;
    if (rd_rand) begin
      rd_en     = ($urandom_range(0, 3) != 0);
      rd_filter = FW'($urandom_range(0, NF - 1));
    end
  endtask

  // mode 0: value=index, 1: value=~index, 2: random
  task automatic send_load(input int n, input int last_idx, input int mode, input bit gaps);
    int g;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        cyc();
      end
      s_valid = 1'b1;
      s_last  = (i == last_idx);
      case (mode)
        0:       s_data = WIDTH'(i);
        1:       s_data = ~WIDTH'(i);
        default: s_data = WIDTH'($urandom);
      endcase
      cyc();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    // T1: reset state and read before any load
    cyc();
    chk_on = 1;
    cyc();
    rst_n = 1'b1;
    cyc();
    rd_en = 1'b1;
    rd_filter = '0;
    cyc();
    rd_en = 1'b0;
    chk("t1_rd_err", {458'd0, rd_err}, 459'd1);
    chk("t1_bank_ready", {458'd0, bank_ready}, 459'd0);
    chk("t1_s_ready", {458'd0, s_ready}, 459'd0);
    cyc();

    // T2: full load value=index, read filter 2
    send_load(DEPTH, DEPTH - 1, 0, 0);
    chk("t2_load_done", {458'd0, load_done}, 459'd1);
    chk("t2_bank_ready", {458'd0, bank_ready}, 459'd1);
    cyc();
    rd_en = 1'b1;
    rd_filter = FW'(2);
    cyc();
    rd_en = 1'b0;
    chk("t2_rd_valid", {458'd0, rd_valid}, 459'd1);
    for (int j = 0; j < KS; j++)
      chk("t2_elem", {442'd0, elem(j)}, {442'd0, WIDTH'(54 + j)});
    cyc();

    // T3: early s_last, then missing s_last
    send_load(50, 49, 2, 0);
    chk("t3_early_err", {458'd0, load_err}, 459'd1);
    cyc();
`ifdef WBANK_PINGPONG_EN
    chk("t3_bank_ready", {458'd0, bank_ready}, 459'd1);
`else
    chk("t3_bank_ready", {458'd0, bank_ready}, 459'd0);
`endif
    rd_en = 1'b1;
    rd_filter = FW'(2);
    cyc();
    rd_en = 1'b0;
`ifdef WBANK_PINGPONG_EN
    chk("t3_old_data", {442'd0, elem(0)}, {442'd0, WIDTH'(54)});
`else
    chk("t3_rd_err", {458'd0, rd_err}, 459'd1);
`endif
    send_load(DEPTH, -1, 2, 0);
    chk("t3_nolast_err", {458'd0, load_err}, 459'd1);
    cyc();

    // T4: random data with gaps, random back-to-back reads throughout
    rd_rand = 1;
    send_load(DEPTH, DEPTH - 1, 2, 1);
    repeat (200) cyc();
    rd_rand = 0;
    rd_en = 1'b0;
    cyc();

    // T5: abort at word 30, reload with ~index; then reset mid-load
    send_load(30, -1, 0, 0);
    send_load(DEPTH, DEPTH - 1, 1, 0);
    cyc();
    rd_en = 1'b1;
    rd_filter = FW'(3);
    cyc();
    chk("t5_f3_e26", {442'd0, elem(26)}, {442'd0, 17'h1FF94});
    rd_filter = FW'(0);
    cyc();
    rd_en = 1'b0;
    chk("t5_f0_e0", {442'd0, elem(0)}, {442'd0, 17'h1FFFF});
    send_load(60, -1, 2, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_reset_ready", {458'd0, bank_ready}, 459'd0);
    chk("t5_reset_sready", {458'd0, s_ready}, 459'd0);
    cyc();

`ifdef WBANK_PINGPONG_EN
    // T6: set A, then set B loaded under continuous reads
    send_load(DEPTH, DEPTH - 1, 0, 0);
    cyc();
    rd_rand = 1;
    send_load(DEPTH, DEPTH - 1, 1, 1);
    rd_rand = 0;
    rd_en = 1'b1;
    rd_filter = FW'(1);
    cyc();
    chk("t6_commit_old", {442'd0, elem(0)}, {442'd0, WIDTH'(27)});
    cyc();
    rd_en = 1'b0;
    chk("t6_after_new", {442'd0, elem(0)}, {442'd0, 17'h1FFE4});
    cyc();
`endif

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
